fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- fetchingAddressWidth, 64, instruction address width.
- instructionWidth, 32, instruction word width.
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- instructionCounterWidth, 64, instruction major ID width.
- queueDepth, 16, number of entries (power of 2).
- stallSlack, 6, free-entry threshold for back-pressure.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clock_i, in, 1, sole clock; all state changes on its rising edge.
- reset_i, in, 1, asynchronous active-high reset.
- flush_i, in, 1, synchronous queue flush.
- fetchEnable1_i / fetchEnable2_i, in, 1 each, slot valids from L1I cache.
- fetchedInstruction1_i / fetchedInstruction2_i, in, instructionWidth each, instruction words.
- fetchedAddress1_i / fetchedAddress2_i, in, fetchingAddressWidth each, instruction addresses.
- fetchedPid1_i / fetchedPid2_i, in, PidSize each, process IDs.
- fetchedTid1_i / fetchedTid2_i, in, TidSize each, thread IDs.
- fetchedInstMajorId1_i / fetchedInstMajorId2_i, in, instructionCounterWidth each, instruction major IDs.
- decodeStall_i, in, 1, decoder cannot accept.
- enable_o, out, 1, output entry valid.
- instruction_o, out, instructionWidth, dequeued instruction word.
- address_o, out, fetchingAddressWidth, dequeued address.
- pid_o, out, PidSize, dequeued process ID.
- tid_o, out, TidSize, dequeued thread ID.
- instMajorId_o, out, instructionCounterWidth, dequeued major ID.
- fetchStall_o, out, 1, back-pressure to L1I cache.
- overflow_o, out, 1, sticky dropped-write flag.
- count_o, out, log2(queueDepth)+1, current occupancy.

Function
REQ-003 SHALL be a circular buffer of queueDepth entries; each entry holds {instruction, address, pid, tid, majorId}; head/tail pointers wrap modulo queueDepth.
REQ-004 SHALL write up to two entries per edge, in order: slot 1 before slot 2; a valid slot 2 with an invalid slot 1 SHALL be written as a single entry at the tail.
REQ-005 SHALL accept a write only when free entries (queueDepth - count) >= number of valid slots. Otherwise it SHALL drop both slots, leave the tail unchanged, and set overflow_o.
REQ-006 SHALL pop the head into the output registers on an edge when count > 0 and (enable_o == 0 or decodeStall_i == 0). The pop SHALL set enable_o = 1.
REQ-007 SHALL clear enable_o to 0 on an edge when enable_o == 1, decodeStall_i == 0 and count == 0.
REQ-008 SHALL hold all outputs unchanged while enable_o == 1 and decodeStall_i == 1.
REQ-009 SHALL have a minimum latency of one edge: an entry written at edge N appears on the outputs at edge N+1 at the earliest. There is no same-edge bypass.
REQ-010 SHALL evaluate pop eligibility on the pre-edge count. The next count SHALL be count + accepted writes - pop; simultaneous push and pop are legal at any occupancy, including full.
REQ-011 SHALL drive fetchStall_o combinationally as (queueDepth - count) < stallSlack.
REQ-012 SHALL give flush_i priority over all other activity. On a flush edge it SHALL:
- zero the pointers and count;
- clear enable_o;
- drop same-edge writes and the same-edge pop;
- leave overflow_o unchanged.
REQ-013 SHALL drive count_o directly from the occupancy register.

Reset
REQ-014 SHALL, while reset_i is high and asynchronously, set:
- head, tail and count = 0;
- enable_o = 0 and overflow_o = 0;
- instruction_o, address_o, pid_o, tid_o and instMajorId_o = 0.
REQ-015 SHALL need no reset for entry storage contents.
REQ-016 SHALL clear all in-flight state when reset is asserted mid-operation; fetchStall_o then reads 0.

Verification
REQ-017 The bench SHALL cover:
- Dual write: both slots valid, instructions 0xAAAAAAAA at address 0x4 and 0xBBBBBBBB at 0x8, decodeStall_i=0 -> enable_o=1 with 0xAAAAAAAA/0x4 at the next edge, then 0xBBBBBBBB/0x8, then enable_o=0; count_o goes 2,1,0.
- Slot-2-only write: 0xCCCCCCCC at address 0x10 -> single entry, count_o=1, dequeued correctly.
- Fill: decodeStall_i=1 with dual writes until count_o=16 -> fetchStall_o rises when count_o=11; a further dual write is dropped, overflow_o=1, count unchanged.
- Wrap and concurrent push/pop at full: 20 instructions streamed with a stall pattern -> output order and IDs match input order; no loss beyond the REQ-005 drops.
- Flush with simultaneous dual write and pop -> next edge count_o=0, enable_o=0, overflow_o retained.
- Asynchronous reset asserted between edges while count_o=5 -> outputs zero immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: dual-slot circular instruction queue between the L1I cache and the decoder
module fetch_queue #(
    parameter int fetchingAddressWidth    = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 16,
    parameter int stallSlack              = 6
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               fetchEnable1_i,
    input  logic                               fetchEnable2_i,
    input  logic [instructionWidth-1:0]        fetchedInstruction1_i,
    input  logic [instructionWidth-1:0]        fetchedInstruction2_i,
    input  logic [fetchingAddressWidth-1:0]    fetchedAddress1_i,
    input  logic [fetchingAddressWidth-1:0]    fetchedAddress2_i,
    input  logic [PidSize-1:0]                 fetchedPid1_i,
    input  logic [PidSize-1:0]                 fetchedPid2_i,
    input  logic [TidSize-1:0]                 fetchedTid1_i,
    input  logic [TidSize-1:0]                 fetchedTid2_i,
    input  logic [instructionCounterWidth-1:0] fetchedInstMajorId1_i,
    input  logic [instructionCounterWidth-1:0] fetchedInstMajorId2_i,
    input  logic                               decodeStall_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [fetchingAddressWidth-1:0]    address_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [instructionCounterWidth-1:0] instMajorId_o,
    output logic                               fetchStall_o,
    output logic                               overflow_o,
    output logic [$clog2(queueDepth):0]        count_o
);
    localparam int ptrWidth   = $clog2(queueDepth);
    localparam int countWidth = ptrWidth + 1;
    localparam int entryWidth = instructionWidth + fetchingAddressWidth + PidSize + TidSize + instructionCounterWidth;
    localparam logic [countWidth-1:0] depth = countWidth'(queueDepth);

    logic [entryWidth-1:0] storage [queueDepth];
    logic [ptrWidth-1:0]   head, tail;
    logic [countWidth-1:0] count, freeEntries, numValid, pushCount;
    logic [entryWidth-1:0] entry1, entry2, headEntry;
    logic                  accept, push, pop;

    // Admission, pop eligibility and back-pressure, all from pre-edge occupancy
    always_comb begin
        entry1       = {fetchedInstruction1_i, fetchedAddress1_i, fetchedPid1_i, fetchedTid1_i, fetchedInstMajorId1_i};
        entry2       = {fetchedInstruction2_i, fetchedAddress2_i, fetchedPid2_i, fetchedTid2_i, fetchedInstMajorId2_i};
        numValid     = countWidth'(fetchEnable1_i) + countWidth'(fetchEnable2_i);
        freeEntries  = depth - count;
        accept       = freeEntries >= numValid;
        push         = accept && numValid != '0;
        pushCount    = push ? numValid : '0;
        pop          = count != '0 && (!enable_o || !decodeStall_i);
        headEntry    = storage[head];
        fetchStall_o = freeEntries < countWidth'(stallSlack);
        count_o      = count;
    end

    // Entry storage: a lone valid slot (either one) lands at the tail, a pair fills tail and tail+1
    always_ff @(posedge clock_i) begin
        if (!flush_i && push) begin
            storage[tail] <= fetchEnable1_i ? entry1 : entry2;
            if (fetchEnable1_i && fetchEnable2_i) storage[tail + ptrWidth'(1)] <= entry2;
        end
    end

    // Pointers, occupancy, sticky overflow and the registered output entry
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            enable_o      <= 1'b0;
            overflow_o    <= 1'b0;
            instruction_o <= '0;
            address_o     <= '0;
            pid_o         <= '0;
            tid_o         <= '0;
            instMajorId_o <= '0;
        end else if (flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            enable_o <= 1'b0;
        end else begin
            if (!accept) overflow_o <= 1'b1;
            tail  <= tail + ptrWidth'(pushCount);
            count <= count + pushCount - countWidth'(pop);
            if (pop) begin
                head     <= head + ptrWidth'(1);
                enable_o <= 1'b1;
                {instruction_o, address_o, pid_o, tid_o, instMajorId_o} <= headEntry;
            end else if (!decodeStall_i) begin
                enable_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] addr;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [63:0] mid;
    } entryType;

    logic        clock_i = 0, reset_i = 1, flush_i = 0, decodeStall_i = 0;
    logic        fetchEnable1_i = 0, fetchEnable2_i = 0;
    entryType    slot1 = '0, slot2 = '0;
    logic        enable_o, fetchStall_o, overflow_o;
    logic [31:0] instruction_o;
    logic [63:0] address_o, instMajorId_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [4:0]  count_o;

    int       checks = 0, errors = 0;
    entryType mq[$];
    entryType mOut = '0;
    logic     mEn = 0, mOvf = 0;
    longint   serial = 0;

    fetch_queue dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .fetchEnable1_i(fetchEnable1_i), .fetchEnable2_i(fetchEnable2_i),
        .fetchedInstruction1_i(slot1.ins), .fetchedInstruction2_i(slot2.ins),
        .fetchedAddress1_i(slot1.addr), .fetchedAddress2_i(slot2.addr),
        .fetchedPid1_i(slot1.pid), .fetchedPid2_i(slot2.pid),
        .fetchedTid1_i(slot1.tid), .fetchedTid2_i(slot2.tid),
        .fetchedInstMajorId1_i(slot1.mid), .fetchedInstMajorId2_i(slot2.mid),
        .decodeStall_i(decodeStall_i), .enable_o(enable_o),
        .instruction_o(instruction_o), .address_o(address_o), .pid_o(pid_o),
        .tid_o(tid_o), .instMajorId_o(instMajorId_o), .fetchStall_o(fetchStall_o),
        .overflow_o(overflow_o), .count_o(count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compareAll(string tag);
        check({tag, ".enable"}, enable_o, mEn);
        check({tag, ".count"}, count_o, mq.size());
        check({tag, ".stall"}, fetchStall_o, (16 - mq.size()) < 6);
        check({tag, ".overflow"}, overflow_o, mOvf);
        check({tag, ".data"}, {instruction_o, address_o, pid_o, tid_o, instMajorId_o}, mOut);
    endtask

    task automatic step(string tag);
        logic f, e1, e2, s;
        entryType d1, d2;
        int nv;
        bit popOk;
        f = flush_i; e1 = fetchEnable1_i; e2 = fetchEnable2_i; s = decodeStall_i; d1 = slot1; d2 = slot2;
        @(posedge clock_i);
        #1;
        if (f) begin
            mq.delete();
            mEn = 0;
        end else begin
            nv = int'(e1) + int'(e2);
            popOk = mq.size() > 0 && (!mEn || !s);
            if (popOk) begin
                mOut = mq.pop_front();
                mEn = 1;
            end else if (!s) mEn = 0;
            if (16 - (mq.size() + int'(popOk)) < nv) mOvf = 1;
            else begin
                if (e1) mq.push_back(d1);
                if (e2) mq.push_back(d2);
            end
        end
        compareAll(tag);
    endtask

    function automatic entryType randEntry();
        entryType e;
        serial++;
        e.ins = $urandom; e.addr = {$urandom, $urandom}; e.pid = 20'($urandom);
        e.tid = 16'($urandom); e.mid = 64'(serial);
        return e;
    endfunction

    task automatic idle();
        fetchEnable1_i = 0; fetchEnable2_i = 0; flush_i = 0;
    endtask

    initial begin
        #12;
        compareAll("reset");
        reset_i = 0;

        slot1 = '{ins: 32'hAAAAAAAA, addr: 64'h4, pid: 20'h1, tid: 16'h1, mid: 64'h1};
        slot2 = '{ins: 32'hBBBBBBBB, addr: 64'h8, pid: 20'h1, tid: 16'h1, mid: 64'h2};
        fetchEnable1_i = 1; fetchEnable2_i = 1;
        step("dualWrite");
        check("dual.count2", count_o, 2);
        check("dual.noBypass", enable_o, 0);
        idle();
        step("dualPop1");
        check("dual.first", {enable_o, instruction_o, address_o}, {1'b1, 32'hAAAAAAAA, 64'h4});
        check("dual.count1", count_o, 1);
        step("dualPop2");
        check("dual.second", {enable_o, instruction_o, address_o}, {1'b1, 32'hBBBBBBBB, 64'h8});
        check("dual.count0", count_o, 0);
        step("dualDrain");
        check("dual.empty", enable_o, 0);

        slot2 = '{ins: 32'hCCCCCCCC, addr: 64'h10, pid: 20'h2, tid: 16'h2, mid: 64'h3};
        fetchEnable2_i = 1;
        step("slot2Write");
        check("slot2.count", count_o, 1);
        idle();
        step("slot2Pop");
        check("slot2.out", {enable_o, instruction_o, address_o}, {1'b1, 32'hCCCCCCCC, 64'h10});
        step("slot2Drain");

        decodeStall_i = 1;
        for (int g = 0; g < 40 && mq.size() < 16; g++) begin
            slot1 = randEntry(); slot2 = randEntry();
            fetchEnable1_i = 1; fetchEnable2_i = (16 - mq.size()) >= 2;
            step("fill");
            if (count_o == 9) check("fill.noStallAt9", fetchStall_o, 0);
            if (count_o == 11) check("fill.stallAt11", fetchStall_o, 1);
        end
        check("fill.full", count_o, 16);
        slot1 = randEntry(); slot2 = randEntry();
        fetchEnable1_i = 1; fetchEnable2_i = 1;
        step("overflow");
        check("overflow.flag", overflow_o, 1);
        check("overflow.count", count_o, 16);

        for (int i = 0; i < 20; i++) begin
            slot1 = randEntry(); slot2 = randEntry();
            fetchEnable1_i = 1; fetchEnable2_i = i[0];
            decodeStall_i = (i % 3) == 0;
            step("stream");
        end
        idle();
        decodeStall_i = 0;
        for (int i = 0; i < 20; i++) step("drain");
        check("drain.empty", {enable_o, count_o}, 0);

        for (int i = 0; i < 400; i++) begin
            slot1 = randEntry(); slot2 = randEntry();
            fetchEnable1_i = 1'($urandom_range(0, 1));
            fetchEnable2_i = 1'($urandom_range(0, 1));
            decodeStall_i = $urandom_range(0, 2) != 0;
            flush_i = $urandom_range(0, 40) == 0;
            step("random");
        end

        idle();
        decodeStall_i = 0;
        slot1 = randEntry(); slot2 = randEntry();
        fetchEnable1_i = 1; fetchEnable2_i = 1;
        step("preFlush");
        step("preFlush");
        flush_i = 1;
        step("flush");
        check("flush.count", count_o, 0);
        check("flush.enable", enable_o, 0);
        check("flush.overflowKept", overflow_o, 1);

        idle();
        decodeStall_i = 1;
        for (int g = 0; g < 20 && mq.size() < 5; g++) begin
            slot1 = randEntry();
            fetchEnable1_i = 1;
            step("toFive");
        end
        idle();
        check("preReset.count", count_o, 5);
        #2;
        reset_i = 1;
        #1;
        mq.delete(); mEn = 0; mOvf = 0; mOut = '0;
        compareAll("asyncReset");
        check("asyncReset.stall", fetchStall_o, 0);
        #1;
        reset_i = 0;
        decodeStall_i = 0;
        step("afterReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
